fp_norm_round_pipe: RTL

- Parametrised, pipelined successor to the adder's normaliser stage.
- Takes the raw sum/difference mantissa (carry, hidden, fraction, guard/round/sticky) and the larger operand's biased exponent.
- Normalises, rounds under a selectable IEEE-754 rounding mode, and handles zero, overflow and underflow.
- Emits a packed result and flags through a 2-stage valid/ready pipeline. It sits between the mantissa add/sub datapath and the result register of the FP adder.

---
 rtl/fp_norm_pkg.sv | 26 ++
 rtl/fp_norm_round_pipe_lod.sv | 22 ++
 rtl/fp_norm_round_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared types and constants for the FP normalise/round pipeline
package fp_norm_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rm_e;

  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_INX  = 1;
  localparam int FLG_ZERO = 0;

  localparam int HALF_EXP_W    = 5;
  localparam int HALF_FRAC_W   = 10;
  localparam int HALF_BIAS     = 15;
  localparam int SINGLE_EXP_W  = 8;
  localparam int SINGLE_FRAC_W = 23;
  localparam int SINGLE_BIAS   = 127;
  localparam int DOUBLE_EXP_W  = 11;
  localparam int DOUBLE_FRAC_W = 52;
  localparam int DOUBLE_BIAS   = 1023;

endpackage

// File: rtl/fp_norm_round_pipe_lod.sv
// rtl/fp_norm_round_pipe_lod.sv - parametrised leading-one priority encoder
module lead_one_detect #(
  parameter int W  = 28,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  din,
  output logic [IW-1:0] idx,
  output logic          zero
);

  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        idx  = IW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// rtl/fp_norm_round_pipe.sv - two-stage normalise/round/exception stage of the FP adder
import fp_norm_pkg::*;

module fp_norm_round_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 2**(EXP_W-1)-1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+4:0]         in_mant,
  input  logic [1:0]                in_rm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic [3:0]                out_flags
);

  localparam int M   = FRAC_W + 5;
  localparam int NM  = FRAC_W + 3;
  localparam int E   = EXP_W + 2;
  localparam int IW  = $clog2(M);
  localparam int HID = FRAC_W + 3;
  localparam logic [EXP_W-1:0] EXP_INF  = EXP_W'(2 * BIAS + 1);
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_W'(2 * BIAS);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s1_sign_q, s1_sign_d;
  rm_e               s1_rm_q, s1_rm_d;
  logic              s1_zero_q, s1_zero_d;
  logic [E-1:0]      s1_exp_q, s1_exp_d;
  logic [NM-1:0]     s1_mant_q, s1_mant_d;
  logic [EXP_W+FRAC_W:0] out_result_q, out_result_d;
  logic [3:0]        out_flags_q, out_flags_d;

  logic s1_load, s2_load;
  logic [IW-1:0] lead_idx;
  logic          lead_zero;

  lead_one_detect #(.W(M), .IW(IW)) u_lod (
    .din  (in_mant),
    .idx  (lead_idx),
    .zero (lead_zero)
  );

  always_comb begin
    s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_load;
    s1_load  = in_valid & in_ready;
  end

  // Stage 1: the hidden bit is implied after normalisation, so only fraction+GRS is kept.
  logic [IW-1:0] sh;
  logic [E-1:0]  exp_ext, n_exp;
  logic [NM-1:0] n_mant;

  always_comb begin
    sh      = IW'(HID) - lead_idx;
    exp_ext = {2'b00, in_exp};
    if (in_mant[M-1]) begin
      n_mant = {in_mant[M-2:2], |in_mant[1:0]};
      n_exp  = exp_ext + E'(1);
    end else begin
      n_mant = in_mant[NM-1:0] << sh;
      n_exp  = exp_ext - E'(sh);
    end
    s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
    s1_sign_d  = s1_load ? in_sign      : s1_sign_q;
    s1_rm_d    = s1_load ? rm_e'(in_rm) : s1_rm_q;
    s1_zero_d  = s1_load ? lead_zero    : s1_zero_q;
    s1_exp_d   = s1_load ? n_exp        : s1_exp_q;
    s1_mant_d  = s1_load ? n_mant       : s1_mant_q;
  end

  // Stage 2: round, then apply zero / overflow / underflow overrides.
  logic              inexact, round_up, to_inf, ovf, unf;
  logic [FRAC_W:0]   rnd_sum;
  logic [E-1:0]      e2;
  logic [EXP_W+FRAC_W:0] rnd_result;
  logic [3:0]        rnd_flags;

  always_comb begin
    inexact  = |s1_mant_q[2:0];
    round_up = 1'b0;
    case (s1_rm_q)
      RM_RNE:  round_up = s1_mant_q[2] & (s1_mant_q[1] | s1_mant_q[0] | s1_mant_q[3]);
      RM_RTZ:  round_up = 1'b0;
      RM_RUP:  round_up = inexact & ~s1_sign_q;
      RM_RDN:  round_up = inexact & s1_sign_q;
      default: round_up = 1'b0;
    endcase
    // A fraction carry-out means the mantissa rolled over to 2.0: frac wraps to 0, exp+1.
    rnd_sum = {1'b0, s1_mant_q[NM-1:3]} + {{FRAC_W{1'b0}}, round_up};
    e2      = s1_exp_q + {{(E-1){1'b0}}, rnd_sum[FRAC_W]};
    ovf     = ~e2[E-1] & (e2 >= {2'b00, EXP_INF});
    unf     = e2[E-1] | (e2 == '0);
    to_inf  = (s1_rm_q == RM_RNE) | ((s1_rm_q == RM_RUP) & ~s1_sign_q) |
              ((s1_rm_q == RM_RDN) & s1_sign_q);

    rnd_result         = {s1_sign_q, e2[EXP_W-1:0], rnd_sum[FRAC_W-1:0]};
    rnd_flags          = '0;
    rnd_flags[FLG_INX] = inexact;
    if (s1_zero_q) begin
      rnd_result          = {s1_rm_q == RM_RDN, {(EXP_W+FRAC_W){1'b0}}};
      rnd_flags           = '0;
      rnd_flags[FLG_ZERO] = 1'b1;
    end else if (ovf) begin
      rnd_result         = to_inf ? {s1_sign_q, EXP_INF, {FRAC_W{1'b0}}}
                                  : {s1_sign_q, EXP_MAXF, {FRAC_W{1'b1}}};
      rnd_flags          = '0;
      rnd_flags[FLG_OVF] = 1'b1;
      rnd_flags[FLG_INX] = 1'b1;
    end else if (unf) begin
      rnd_result          = {s1_sign_q, {(EXP_W+FRAC_W){1'b0}}};
      rnd_flags           = '0;
      rnd_flags[FLG_UNF]  = 1'b1;
      rnd_flags[FLG_INX]  = 1'b1;
      rnd_flags[FLG_ZERO] = 1'b1;
    end

    s2_valid_d   = s2_load | (s2_valid_q & ~out_ready);
    out_result_d = s2_load ? rnd_result : out_result_q;
    out_flags_d  = s2_load ? rnd_flags  : out_flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_rm_q      <= RM_RNE;
      s1_zero_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_rm_q      <= s1_rm_d;
      s1_zero_q    <= s1_zero_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule
